sm3_job_ctrl: RTL and testbench

- Sequences the SM3 hash core for the RV32IM pipeline: accepts one hash job (32-bit message word plus destination byte address) and loads the word into the core.
- Waits for the core's hash-ready indication, then writes the 256-bit digest to data memory as eight 32-bit stores.
- Holds the CPU pipeline while busy, clears the core between jobs, and flags a core timeout.

---
 rtl/sm3_pkg.sv | 28 ++
 rtl/sm3_hash_serializer.sv | 70 +++++++
 rtl/sm3_job_ctrl.sv | 156 +++++++++++++++
 tb/tb_sm3_job_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm3_pkg
// Description : Shared definitions for the SM3 job controller. It holds the
//               controller state encoding, the digest word count and the SM3
//               initial value.
// Revision    : 1.0 - initial release
// ============================================================================
package sm3_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        SM3_ST_IDLE  = 3'd0,
        SM3_ST_LOAD  = 3'd1,
        SM3_ST_RUN   = 3'd2,
        SM3_ST_WRITE = 3'd3,
        SM3_ST_CLEAR = 3'd4
    } sm3_state_e;

    // The 256-bit digest is written to memory as this many 32-bit words
    localparam int SM3_WORDS = 8;

    // SM3 initial value (registers A..H, A in the top word)
    localparam logic [255:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

endpackage : sm3_pkg
`default_nettype wire

// File: rtl/sm3_hash_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sm3_hash_serializer
// Description : Captures the 256-bit SM3 digest and streams it to data memory
//               as eight 32-bit stores, most significant word (register A)
//               first, at consecutive word addresses from the job base.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst   - clock, synchronous active-high reset
//   capture    - load hash_in into the capture register, restart at word 0
//   hash_in    - digest from the SM3 core
//   base_addr  - word-aligned destination byte address
//   active     - controller is in its write phase
//   mem_ack    - store accepted by memory
//   mem_req    - store request
//   mem_addr   - store byte address (wraps modulo 2^ADDR_W)
//   mem_wdata  - store data
//   last_ack   - the final word was accepted this cycle
// ============================================================================
module sm3_hash_serializer
    import sm3_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [255:0]      hash_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              active,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              last_ack
);

    localparam int                 c_idx_w    = $clog2(SM3_WORDS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(SM3_WORDS - 1);

    logic [255:0]       r_hash;
    logic [c_idx_w-1:0] r_idx;
    logic [31:0]        w_words [SM3_WORDS];

    // Word 0 is the most significant 32 bits of the digest
    for (genvar gi = 0; gi < SM3_WORDS; gi++) begin : g_words
        assign w_words[gi] = r_hash[255 - 32*gi -: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hash <= '0;
            r_idx  <= '0;
        end else if (capture) begin
            r_hash <= hash_in;
            r_idx  <= '0;
        end else if (active && mem_ack) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    // Address and data are pure functions of the index, so they hold steady
    // for as long as memory withholds its acknowledge.
    assign mem_req   = active;
    assign mem_addr  = active ? (base_addr + ADDR_W'({r_idx, 2'b00})) : '0;
    assign mem_wdata = active ? w_words[r_idx] : '0;
    assign last_ack  = active && mem_ack && (r_idx == c_idx_last);

endmodule : sm3_hash_serializer
`default_nettype wire

// File: rtl/sm3_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sm3_job_ctrl
// Description : Sequences one SM3 hash job for the CPU pipeline: loads the
//               message word into the core, waits for the digest (with a
//               timeout), stores the digest to memory and resets the core
//               before the next job. The pipeline is stalled while busy.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/ready           - job handshake from the CPU
//   cmd_msg, cmd_addr         - message word and destination byte address
//   core_rst_n                - active-low reset to the SM3 core
//   core_valid_in/m_load      - core run enable and message load strobe
//   core_message              - message word to the core
//   core_save_hash, core_hash - digest ready and digest from the core
//   mem_req/addr/wdata/ack    - store port to data memory
//   stall                     - hold the CPU pipeline
//   done, err                 - completion and timeout-abort pulses
// ============================================================================
module sm3_job_ctrl
    import sm3_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 200,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_msg,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              core_rst_n,
    output logic              core_valid_in,
    output logic              core_m_load,
    output logic [31:0]       core_message,
    input  logic              core_save_hash,
    input  logic [255:0]      core_hash,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_st_idle  = SM3_ST_IDLE;
    localparam logic [2:0] c_st_load  = SM3_ST_LOAD;
    localparam logic [2:0] c_st_run   = SM3_ST_RUN;
    localparam logic [2:0] c_st_write = SM3_ST_WRITE;
    localparam logic [2:0] c_st_clear = SM3_ST_CLEAR;

    // One counter serves both the RUN timeout and the CLEAR hold time
    localparam int                 c_cnt_max  = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int                 c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_clr_load = c_cnt_w'(CLR_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_msg;
    logic [ADDR_W-1:0]  r_base;

    logic w_capture;
    logic w_timeout;
    logic w_write;
    logic w_last_ack;

    // A digest arriving in the final RUN cycle takes priority over the abort
    assign w_capture = (r_state == c_st_run) && core_save_hash;
    assign w_timeout = (r_state == c_st_run) && !core_save_hash && (r_cnt == c_to_last);
    assign w_write   = (r_state == c_st_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_clear;
            r_cnt   <= c_clr_load;
            r_msg   <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_msg   <= cmd_msg;
                        // Low address bits are dropped to force word alignment
                        r_base  <= cmd_addr & ~ADDR_W'(3);
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_cnt   <= '0;
                    r_state <= c_st_run;
                end
                c_st_run: begin
                    if (w_capture) begin
                        r_state <= c_st_write;
                    end else if (w_timeout) begin
                        r_cnt   <= c_clr_load;
                        r_state <= c_st_clear;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                c_st_write: begin
                    if (w_last_ack) begin
                        r_cnt   <= c_clr_load;
                        r_state <= c_st_clear;
                    end
                end
                c_st_clear: begin
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= c_clr_load;
                    r_state <= c_st_clear;
                end
            endcase
        end
    end

    sm3_hash_serializer #(
        .ADDR_W    (ADDR_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .capture   (w_capture),
        .hash_in   (core_hash),
        .base_addr (r_base),
        .active    (w_write),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .last_ack  (w_last_ack)
    );

    assign cmd_ready     = (r_state == c_st_idle);
    // In IDLE the stall follows cmd_valid directly so the issuing instruction
    // is held in the same cycle it presents the job.
    assign stall         = (r_state != c_st_idle) || cmd_valid;
    assign core_rst_n    = (r_state != c_st_clear);
    assign core_m_load   = (r_state == c_st_load);
    assign core_valid_in = (r_state == c_st_run);
    assign core_message  = r_msg;
    assign done          = w_last_ack;
    assign err           = w_timeout;

endmodule : sm3_job_ctrl
`default_nettype wire

// File: tb/tb_sm3_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm3_job_ctrl
// Description : Self-checking bench for sm3_job_ctrl. A behavioural SM3 core
//               and memory responder drive the DUT; expected stores are the
//               digest words at base+4*i, compared as memory sees them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm3_job_ctrl;
    import sm3_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_msg;
    logic [31:0]  cmd_addr;
    logic         core_rst_n;
    logic         core_valid_in;
    logic         core_m_load;
    logic [31:0]  core_message;
    logic         core_save_hash;
    logic [255:0] core_hash;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic         stall;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural environment controls
    int           core_lat = 0;   // RUN cycle in which save_hash rises, 0 = never
    int           ack_wait = 0;   // ack-low cycles per word, -1 = random
    logic [255:0] job_hash = '0;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int store_cnt, done_cnt, err_cnt, done_cyc, err_cyc, first_req_cyc;

    sm3_job_ctrl #(
        .ADDR_W         (32),
        .TIMEOUT        (200),
        .CLR_CYCLES     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_msg        (cmd_msg),
        .cmd_addr       (cmd_addr),
        .core_rst_n     (core_rst_n),
        .core_valid_in  (core_valid_in),
        .core_m_load    (core_m_load),
        .core_message   (core_message),
        .core_save_hash (core_save_hash),
        .core_hash      (core_hash),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .stall          (stall),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] h = '0;
        for (int i = 0; i < 8; i++) h = {h[223:0], 32'($urandom)};
        return h;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SM3 core model: after a load strobe it counts RUN cycles and raises
    // save_hash for one cycle in RUN cycle core_lat.
    initial begin : p_core
        int   run_cnt;
        logic nxt;
        run_cnt = 0;
        core_save_hash = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            nxt = 1'b0;
            if (!core_rst_n) begin
                run_cnt = 0;
            end else if (core_m_load) begin
                run_cnt = 0;
                nxt = (core_lat == 1);
            end else if (core_valid_in && !core_save_hash) begin
                run_cnt++;
                nxt = (core_lat > 1) && (run_cnt == core_lat - 1);
            end
            @(posedge clk);
            #1;
            core_save_hash = nxt;
            core_hash = job_hash;
        end
    end

    // Memory responder: fixed or random acknowledge delay per word
    initial begin : p_ack
        int   wcnt;
        logic nxt;
        wcnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_wait == 0) begin
                nxt = 1'b1;
            end else if (ack_wait < 0) begin
                nxt = 1'($urandom_range(0, 1));
            end else if (mem_req && !mem_ack) begin
                wcnt++;
                nxt = (wcnt >= ack_wait);
            end else begin
                wcnt = 0;
                nxt = 1'b0;
            end
            @(posedge clk);
            #1;
            mem_ack = nxt;
        end
    end

    // Store monitor: every requested cycle must present the next expected word
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (exp_addr.size() == 0) begin
                check_val("stray_store", 64'(mem_req), 64'(0));
            end else begin
                check_val("store_addr", 64'(mem_addr), 64'(exp_addr[0]));
                check_val("store_data", 64'(mem_wdata), 64'(exp_data[0]));
                if (mem_ack) begin
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                    store_cnt++;
                end
            end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
    end

    task automatic start_job(input logic [31:0] msg, input logic [31:0] addr, input int lat,
                             input int ackw, input logic [255:0] hash, input bit hold,
                             input logic [31:0] nmsg, input logic [31:0] naddr, output int acc);
        logic [31:0] base;
        int n;
        base = addr & 32'hFFFF_FFFC;
        core_lat = lat;
        ack_wait = ackw;
        job_hash = hash;
        exp_addr.delete();
        exp_data.delete();
        if (!(lat == 0 || lat > 200)) begin
            for (int i = 0; i < 8; i++) begin
                exp_addr.push_back(base + 32'(4 * i));
                exp_data.push_back(32'(hash >> (32 * (7 - i))));
            end
        end
        store_cnt = 0; done_cnt = 0; err_cnt = 0; first_req_cyc = -1;
        if (!cmd_valid) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b1; cmd_msg = msg; cmd_addr = addr;
            tick();
        end
        n = 0;
        while (!cmd_ready && n < 500) begin tick(); n++; end
        check_val("cmd_accept", 64'(cmd_ready), 64'(1));
        check_val("stall_on_cmd", 64'(stall), 64'(1));
        acc = cyc;
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_msg = nmsg; cmd_addr = naddr;
        end else begin
            cmd_valid = 1'b0; cmd_msg = $urandom; cmd_addr = $urandom;
        end
        tick();
        check_val("load_strobe", 64'(core_m_load), 64'(1));
        check_val("load_msg", 64'(core_message), 64'(msg));
        check_val("load_valid_in", 64'(core_valid_in), 64'(0));
    endtask

    task automatic finish_job(input int lat, input int acc, input bit hold);
        bit to;
        int n;
        to = (lat == 0 || lat > 200);
        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 4000) begin
            check_val("busy_stall", 64'(stall), 64'(1));
            check_val("busy_ready", 64'(cmd_ready), 64'(0));
            tick();
            n++;
        end
        check_val("job_ended", 64'(done_cnt + err_cnt), 64'(1));
        if (to) begin
            check_val("err_cycle", 64'(err_cyc - acc), 64'(201));
            check_val("err_no_store", 64'(store_cnt), 64'(0));
        end else begin
            check_val("first_req_latency", 64'(first_req_cyc - acc), 64'(2 + lat));
            check_val("store_count", 64'(store_cnt), 64'(8));
        end
        tick();
        check_val("clear1_core_rst_n", 64'(core_rst_n), 64'(0));
        check_val("clear1_stall", 64'(stall), 64'(1));
        check_val("clear1_ready", 64'(cmd_ready), 64'(0));
        tick();
        check_val("clear2_core_rst_n", 64'(core_rst_n), 64'(0));
        tick();
        check_val("idle_core_rst_n", 64'(core_rst_n), 64'(1));
        check_val("idle_ready", 64'(cmd_ready), 64'(1));
        check_val("idle_stall", 64'(stall), 64'(hold));
        check_val("done_pulses", 64'(done_cnt), 64'(to ? 0 : 1));
        check_val("err_pulses", 64'(err_cnt), 64'(to ? 1 : 0));
    endtask

    task automatic run_job(input logic [31:0] msg, input logic [31:0] addr, input int lat,
                           input int ackw, input logic [255:0] hash);
        int acc;
        start_job(msg, addr, lat, ackw, hash, 1'b0, 32'h0, 32'h0, acc);
        finish_job(lat, acc, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int acc1, acc2, d1, n;
        logic [255:0] h1, h2;
        rst = 1'b1; cmd_valid = 1'b0; cmd_msg = '0; cmd_addr = '0;
        repeat (2) tick();
        check_val("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        check_val("rst_ready", 64'(cmd_ready), 64'(0));
        check_val("rst_mem_req", 64'(mem_req), 64'(0));
        check_val("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_val("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check_val("rst_m_load", 64'(core_m_load), 64'(0));
        check_val("rst_valid_in", 64'(core_valid_in), 64'(0));
        check_val("rst_message", 64'(core_message), 64'(0));
        check_val("rst_done_err", 64'({done, err}), 64'(0));
        rst = 1'b0;
        tick();
        check_val("post_rst_clear", 64'(core_rst_n), 64'(0));
        tick();
        check_val("post_rst_idle", 64'(cmd_ready), 64'(1));
        check_val("idle_no_stall", 64'(stall), 64'(0));

        // Basic job
        run_job(32'h6162_6300, 32'h0000_1000, 68, 0,
                256'h00112233_44556677_8899aabb_ccddeeff_00112233_44556677_8899aabb_ccddeeff);
        // Memory backpressure, 3 ack-low cycles per word
        run_job(32'h1234_5678, 32'h0000_2000, 5, 3, SM3_IV);
        // Core never answers: timeout abort
        run_job(32'hdead_beef, 32'h0000_3000, 0, 0, rand_hash());
        // Digest in the very cycle the timeout would fire: capture wins
        run_job(32'hcafe_f00d, 32'h0000_3100, 200, 0, rand_hash());

        // Reset while the fifth word (index 4) is pending
        start_job(32'h0bad_0bad, 32'h0000_4000, 10, 3, rand_hash(), 1'b0, 32'h0, 32'h0, acc1);
        n = 0;
        while (store_cnt < 4 && n < 500) begin tick(); n++; end
        tick();
        check_val("rstw_idx4_addr", 64'(mem_addr), 64'(32'h0000_4010));
        rst = 1'b1;
        tick();
        exp_addr.delete();
        exp_data.delete();
        check_val("rstw_mem_req", 64'(mem_req), 64'(0));
        check_val("rstw_core_rst_n", 64'(core_rst_n), 64'(0));
        rst = 1'b0;
        tick();
        check_val("rstw_clear", 64'(core_rst_n), 64'(0));
        tick();
        check_val("rstw_idle", 64'(cmd_ready), 64'(1));
        check_val("rstw_no_done", 64'(done_cnt), 64'(0));
        run_job(32'h5555_aaaa, 32'h0000_5004, 4, 0, rand_hash());

        // Back-to-back jobs with cmd_valid held throughout
        h1 = rand_hash();
        h2 = rand_hash();
        start_job(32'h1111_1111, 32'h0000_6000, 7, 0, h1, 1'b1, 32'h2222_2222, 32'h0000_7000, acc1);
        finish_job(7, acc1, 1'b1);
        d1 = done_cyc;
        start_job(32'h2222_2222, 32'h0000_7000, 9, -1, h2, 1'b0, 32'h0, 32'h0, acc2);
        check_val("b2b_accept_after_clear", 64'(acc2 - d1), 64'(3));
        finish_job(9, acc2, 1'b0);

        // Address wrap past the top of memory
        run_job(32'h7777_0000, 32'hFFFF_FFF0, 3, 0, rand_hash());

        // Randomized jobs, unaligned addresses allowed
        for (int j = 0; j < 6; j++) begin
            run_job($urandom, $urandom, int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 3)) - 1, rand_hash());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sm3_job_ctrl
`default_nettype wire
